// File: rtl/fetch_ctrl_multi_if.sv
// fetch_ctrl_multi_if: fetch control signals between the pipeline and the fetch sequencer
interface fetch_ctrl_multi_if #(
  parameter int OPC_W = 4,
  parameter int MAX_WORDS = 3,
  parameter int NUM_IRQ = 2
);
  localparam int EW = $clog2(MAX_WORDS) + 1;
  localparam int VW = $clog2(NUM_IRQ + 1);
  logic [NUM_IRQ-1:0] intr_req;
  logic intr_en;
  logic stall_in;
  logic [OPC_W-1:0] opcode;
  logic [1:0] brx;
  logic [EW-1:0] extra_words;
  logic branch_taken;
  logic bypass_decode_done;
  logic pc_en;
  logic pc_load;
  logic [1:0] pc_src;
  logic [VW-1:0] vec_sel;
  logic sf1;
  logic [NUM_IRQ-1:0] int_ack;
  logic stall;
  logic flush_next;
  logic multiword;
  modport master (
    output intr_req, intr_en, stall_in, opcode, brx, extra_words, branch_taken, bypass_decode_done,
    input pc_en, pc_load, pc_src, vec_sel, sf1, int_ack, stall, flush_next, multiword
  );
  modport slave (
    input intr_req, intr_en, stall_in, opcode, brx, extra_words, branch_taken, bypass_decode_done,
    output pc_en, pc_load, pc_src, vec_sel, sf1, int_ack, stall, flush_next, multiword
  );
endinterface

// File: rtl/fetch_ctrl_multi.sv
// fetch_ctrl_multi: fetch-stage PC/stall/flush sequencer with multiword, RET wait and prioritised interrupts
module fetch_ctrl_multi #(
  parameter int OPC_W = 4,
  parameter int BR_OPC = 11,
  parameter int MAX_WORDS = 3,
  parameter int RET_WAIT = 2,
  parameter int NUM_IRQ = 2
) (
  input logic clk,
  input logic reset,
  fetch_ctrl_multi_if.slave bus
);
  localparam int EW = $clog2(MAX_WORDS) + 1;
  localparam int VW = $clog2(NUM_IRQ + 1);
  localparam int RW = $clog2(RET_WAIT + 1);
  typedef enum logic [2:0] {S_RESET, S_FETCH, S_EXTRA, S_RET, S_VECTOR} state_t;
  state_t state, nxt;
  logic [NUM_IRQ-1:0] pend;
  logic [EW-1:0] cnt, cnt_n, ew_c;
  logic [RW-1:0] rcnt, rcnt_n;
  logic just_loaded;
  logic is_br;
  int sel;
  assign ew_c = (bus.extra_words > EW'(MAX_WORDS - 1)) ? EW'(MAX_WORDS - 1) : bus.extra_words;
  assign is_br = bus.opcode == OPC_W'(BR_OPC);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_RESET;
      pend <= '0;
      cnt <= '0;
      rcnt <= '0;
      just_loaded <= 1'b1;
    end else begin
      state <= nxt;
      pend <= (pend & ~bus.int_ack) | (bus.intr_en ? bus.intr_req : '0);
      cnt <= cnt_n;
      rcnt <= rcnt_n;
      just_loaded <= bus.pc_load;
    end
  end
  always_comb begin
    nxt = state;
    cnt_n = cnt;
    rcnt_n = rcnt;
    sel = 0;
    bus.pc_en = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_src = 2'b00;
    bus.vec_sel = '0;
    bus.sf1 = 1'b0;
    bus.int_ack = '0;
    bus.stall = 1'b0;
    bus.flush_next = 1'b0;
    bus.multiword = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend[i]) sel = i;
    case (state)
      S_RESET: begin
        bus.pc_en = 1'b1;
        bus.pc_load = 1'b1;
        bus.pc_src = 2'b01;
        nxt = S_FETCH;
      end
      S_FETCH: begin
        if (bus.branch_taken) begin
          bus.pc_en = 1'b1;
          bus.pc_load = 1'b1;
        end else if (is_br && bus.brx[1]) begin
          bus.stall = 1'b1;
          rcnt_n = RW'(1);
          nxt = S_RET;
        end else if (is_br) begin
          bus.pc_en = bus.bypass_decode_done;
          bus.pc_load = bus.bypass_decode_done;
          bus.pc_src = bus.bypass_decode_done ? 2'b10 : 2'b00;
          bus.stall = !bus.bypass_decode_done;
        end else if (bus.intr_en && |pend && !bus.stall_in) begin
          bus.flush_next = 1'b1;
          nxt = S_VECTOR;
        end else begin
          bus.pc_en = !just_loaded && !bus.stall_in;
          if (ew_c != '0 && !bus.stall_in) begin
            cnt_n = ew_c;
            nxt = S_EXTRA;
          end
        end
      end
      S_EXTRA: begin
        bus.multiword = 1'b1;
        bus.pc_en = !bus.stall_in;
        if (!bus.stall_in) begin
          cnt_n = cnt - EW'(1);
          nxt = (cnt == EW'(1)) ? S_FETCH : S_EXTRA;
        end
      end
      S_RET: begin
        bus.flush_next = 1'b1;
        if (rcnt == RW'(RET_WAIT)) begin
          bus.pc_en = 1'b1;
          bus.pc_load = 1'b1;
          bus.pc_src = 2'b11;
          nxt = S_FETCH;
        end else begin
          bus.stall = 1'b1;
          rcnt_n = bus.stall_in ? rcnt : rcnt + RW'(1);
        end
      end
      S_VECTOR: begin
        bus.pc_en = 1'b1;
        bus.pc_load = 1'b1;
        bus.pc_src = 2'b01;
        bus.vec_sel = VW'(sel + 1);
        bus.sf1 = 1'b1;
        bus.int_ack = NUM_IRQ'(1) << sel;
        nxt = S_FETCH;
      end
      default: nxt = S_RESET;
    endcase
  end
endmodule

// File: tb/tb_fetch_ctrl_multi.sv
// tb_fetch_ctrl_multi: directed scoreboard bench for fetch_ctrl_multi with RET_WAIT 2 and 4 instances
module tb_fetch_ctrl_multi;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int fails = 0;
  typedef struct {
    string tag;
    logic [11:0] e;
  } exp_t;
  exp_t sb[$];
  exp_t sb4[$];
  fetch_ctrl_multi_if #(.OPC_W(4), .MAX_WORDS(3), .NUM_IRQ(2)) bus ();
  fetch_ctrl_multi_if #(.OPC_W(4), .MAX_WORDS(3), .NUM_IRQ(2)) bus4 ();
  fetch_ctrl_multi #(.OPC_W(4), .BR_OPC(11), .MAX_WORDS(3), .RET_WAIT(2), .NUM_IRQ(2)) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  fetch_ctrl_multi #(.OPC_W(4), .BR_OPC(11), .MAX_WORDS(3), .RET_WAIT(4), .NUM_IRQ(2)) u_dut4 (
    .clk(clk),
    .reset(reset),
    .bus(bus4)
  );
  assign bus4.intr_req = bus.intr_req;
  assign bus4.intr_en = bus.intr_en;
  assign bus4.stall_in = bus.stall_in;
  assign bus4.opcode = bus.opcode;
  assign bus4.brx = bus.brx;
  assign bus4.extra_words = bus.extra_words;
  assign bus4.branch_taken = bus.branch_taken;
  assign bus4.bypass_decode_done = bus.bypass_decode_done;
  always #5 clk = ~clk;
  function automatic logic [11:0] ex(input logic en, input logic ld, input logic [1:0] src,
      input logic [1:0] vs, input logic sf, input logic [1:0] ack, input logic st,
      input logic fl, input logic mw);
    return {en, ld, src, vs, sf, ack, st, fl, mw};
  endfunction
  wire [11:0] obs = {bus.pc_en, bus.pc_load, bus.pc_src, bus.vec_sel, bus.sf1, bus.int_ack,
                     bus.stall, bus.flush_next, bus.multiword};
  wire [11:0] obs4 = {bus4.pc_en, bus4.pc_load, bus4.pc_src, bus4.vec_sel, bus4.sf1, bus4.int_ack,
                      bus4.stall, bus4.flush_next, bus4.multiword};
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      automatic exp_t x = sb.pop_front();
      checks++;
      assert (obs === x.e) else begin
        fails++;
        $error("FAIL %s observed=%b expected=%b", x.tag, obs, x.e);
      end
    end
    if (sb4.size() > 0) begin
      automatic exp_t y = sb4.pop_front();
      checks++;
      assert (obs4 === y.e) else begin
        fails++;
        $error("FAIL %s observed=%b expected=%b", y.tag, obs4, y.e);
      end
    end
  end
  task automatic step(input string tag, input logic [11:0] e);
    sb.push_back('{tag, e});
    @(posedge clk);
    #1;
  endtask
  task automatic step2(input string tag, input logic [11:0] e, input logic [11:0] e4);
    sb4.push_back('{{tag, "_w4"}, e4});
    step(tag, e);
  endtask
  initial begin
    logic [11:0] z, run, rst_v, stl, ret_f;
    z = ex(0, 0, 2'b00, 2'd0, 0, 2'b00, 0, 0, 0);
    run = ex(1, 0, 2'b00, 2'd0, 0, 2'b00, 0, 0, 0);
    rst_v = ex(1, 1, 2'b01, 2'd0, 0, 2'b00, 0, 0, 0);
    stl = ex(0, 0, 2'b00, 2'd0, 0, 2'b00, 1, 0, 0);
    ret_f = ex(0, 0, 2'b00, 2'd0, 0, 2'b00, 1, 1, 0);
    reset = 1'b0;
    bus.intr_req = '0;
    bus.intr_en = 1'b0;
    bus.stall_in = 1'b0;
    bus.opcode = '0;
    bus.brx = '0;
    bus.extra_words = '0;
    bus.branch_taken = 1'b0;
    bus.bypass_decode_done = 1'b0;
    @(posedge clk);
    #1;
    step("reset_1", rst_v);
    step("reset_2", rst_v);
    reset = 1'b1;
    step("reset_rel", rst_v);
    step("first_fetch", z);
    step("second_fetch", run);
    bus.extra_words = 3'd2;
    step("mw_start", run);
    bus.extra_words = 3'd0;
    step("mw_x1", ex(1, 0, 2'b00, 2'd0, 0, 2'b00, 0, 0, 1));
    bus.stall_in = 1'b1;
    step("mw_x2_stall", ex(0, 0, 2'b00, 2'd0, 0, 2'b00, 0, 0, 1));
    bus.stall_in = 1'b0;
    step("mw_x3", ex(1, 0, 2'b00, 2'd0, 0, 2'b00, 0, 0, 1));
    step("mw_back", run);
    bus.extra_words = 3'd7;
    step("clamp_start", run);
    bus.extra_words = 3'd0;
    step("clamp_x1", ex(1, 0, 2'b00, 2'd0, 0, 2'b00, 0, 0, 1));
    step("clamp_x2", ex(1, 0, 2'b00, 2'd0, 0, 2'b00, 0, 0, 1));
    step("clamp_back", run);
    bus.opcode = 4'd11;
    bus.brx = 2'd2;
    step2("ret_c1", stl, stl);
    bus.opcode = 4'd0;
    bus.brx = 2'd0;
    step2("ret_c2", ret_f, ret_f);
    step2("ret_c3", ex(1, 1, 2'b11, 2'd0, 0, 2'b00, 0, 1, 0), ret_f);
    step2("ret_c4", z, ret_f);
    step2("ret_c5", run, ex(1, 1, 2'b11, 2'd0, 0, 2'b00, 0, 1, 0));
    step2("ret_c6", run, z);
    bus.opcode = 4'd11;
    step("jmp_wait", stl);
    bus.bypass_decode_done = 1'b1;
    step("jmp_load", ex(1, 1, 2'b10, 2'd0, 0, 2'b00, 0, 0, 0));
    bus.opcode = 4'd0;
    bus.bypass_decode_done = 1'b0;
    step("jmp_after", z);
    step("jmp_run", run);
    bus.extra_words = 3'd2;
    step("irq_mw_start", run);
    bus.extra_words = 3'd0;
    bus.intr_en = 1'b1;
    bus.intr_req = 2'b11;
    step("irq_mw_x1", ex(1, 0, 2'b00, 2'd0, 0, 2'b00, 0, 0, 1));
    bus.intr_req = 2'b00;
    step("irq_mw_x2", ex(1, 0, 2'b00, 2'd0, 0, 2'b00, 0, 0, 1));
    step("irq_boundary0", ex(0, 0, 2'b00, 2'd0, 0, 2'b00, 0, 1, 0));
    step("irq_vector0", ex(1, 1, 2'b01, 2'd1, 1, 2'b01, 0, 0, 0));
    step("irq_boundary1", ex(0, 0, 2'b00, 2'd0, 0, 2'b00, 0, 1, 0));
    step("irq_vector1", ex(1, 1, 2'b01, 2'd2, 1, 2'b10, 0, 0, 0));
    step("irq_done", z);
    bus.intr_req = 2'b01;
    step("br_irq_latch", run);
    bus.intr_req = 2'b00;
    bus.branch_taken = 1'b1;
    step("br_first", ex(1, 1, 2'b00, 2'd0, 0, 2'b00, 0, 0, 0));
    bus.branch_taken = 1'b0;
    step("br_irq_boundary", ex(0, 0, 2'b00, 2'd0, 0, 2'b00, 0, 1, 0));
    step("br_irq_vector", ex(1, 1, 2'b01, 2'd1, 1, 2'b01, 0, 0, 0));
    step("br_irq_done", z);
    bus.intr_req = 2'b01;
    step("rereq_latch", run);
    step("rereq_boundary", ex(0, 0, 2'b00, 2'd0, 0, 2'b00, 0, 1, 0));
    step("rereq_vector", ex(1, 1, 2'b01, 2'd1, 1, 2'b01, 0, 0, 0));
    step("rereq_pending", ex(0, 0, 2'b00, 2'd0, 0, 2'b00, 0, 1, 0));
    bus.intr_req = 2'b00;
    step("rereq_vector2", ex(1, 1, 2'b01, 2'd1, 1, 2'b01, 0, 0, 0));
    step("rereq_done", z);
    bus.opcode = 4'd11;
    bus.brx = 2'd3;
    bus.intr_req = 2'b01;
    step("rst_ret_enter", stl);
    bus.opcode = 4'd0;
    bus.brx = 2'd0;
    bus.intr_req = 2'b00;
    reset = 1'b0;
    step("rst_ret_wait", ret_f);
    reset = 1'b1;
    step("rst_ret_reset", rst_v);
    step("rst_ret_nopend", z);
    step("rst_ret_run", run);
    bus.intr_en = 1'b0;
    bus.intr_req = 2'b10;
    step("gate_off1", run);
    step("gate_off2", run);
    bus.intr_req = 2'b00;
    bus.intr_en = 1'b1;
    step("gate_on", run);
    @(negedge clk);
    checks++;
    assert (sb.size() == 0 && sb4.size() == 0) else begin
      fails++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size() + sb4.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
